uart_rx_frame: RTL and testbench

UART receive-side frame engine: the receive counterpart of the TX output stage.
- Runs on an oversampled clock; one CLK cycle equals one oversample tick.
- Hunts for a start bit, majority-votes each bit at mid-bit, deserialises LSB-first, and checks optional parity and the stop bit.
- Presents the captured byte to the host logic with a one-cycle valid pulse and error flags.

---
 rtl/uart_rx_frame_pkg.sv | 22 ++
 rtl/uart_rx_frame_if.sv | 23 ++
 rtl/uart_rx_frame_sampler.sv | 65 ++++++
 rtl/uart_rx_frame.sv | 151 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared types and helpers for the UART receive frame engine.
package uart_pkg;

  // Frame-level FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // PAR_TYP encoding.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Centre tick of a bit; the vote window is centre-1 .. centre+1.
  function automatic int mid_tick(input int os);
    return os / 2;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Host-side bundle: serial line and frame options in, captured byte and status pulses out.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  // master drives the line, slave is the receiver
  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_frame_sampler.sv
// Per-bit timing: oversample tick counter, three-point mid-bit capture and
// majority vote. mid_vld_o marks the tick where the vote becomes known;
// bit_done_o marks the last tick of the bit, with the voted value on bit_o.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,    // idle line seen low: this edge is tick 0
  input  logic active_i,   // frame in progress
  input  logic rx_i,
  output logic mid_vld_o,
  output logic vote_o,
  output logic bit_done_o,
  output logic bit_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LO   = TW'(mid_tick(OVERSAMPLE) - 1);
  localparam logic [TW-1:0] T_MID  = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] T_HI   = TW'(mid_tick(OVERSAMPLE) + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic          bit_q, bit_d;

  // Tick advance, sample capture and vote; the third sample is taken live.
  always_comb begin
    tick_d     = tick_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    bit_d      = bit_q;
    vote_o     = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
    mid_vld_o  = active_i && (tick_q == T_HI);
    bit_done_o = active_i && (tick_q == T_LAST);
    // counter is a power of two wide, so it wraps at each bit boundary
    if (start_i)       tick_d = TW'(1);
    else if (active_i) tick_d = tick_q + TW'(1);
    if (active_i && tick_q == T_LO)  s0_d  = rx_i;
    if (active_i && tick_q == T_MID) s1_d  = rx_i;
    if (mid_vld_o)                   bit_d = vote_o;
  end

  assign bit_o = bit_q;

  // Sampler state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
      bit_q  <= 1'b1;
    end else begin
      tick_q <= tick_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start hunt with glitch reject, LSB-first
// deserialisation, optional parity and stop check, one-cycle result pulses.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic            CLK,
  input  logic            RST,
  uart_rx_frame_if.slave  bus
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shad_q, shad_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  pend_q, pend_d;    // frame finished, report on next edge
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic start, active, mid_vld, vote, bit_done, bit_v;

  assign start  = (state_q == IDLE) && !bus.RX_IN;
  assign active = (state_q != IDLE);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_smp (
    .clk_i      (CLK),
    .rst_i      (RST),
    .start_i    (start),
    .active_i   (active),
    .rx_i       (bus.RX_IN),
    .mid_vld_o  (mid_vld),
    .vote_o     (vote),
    .bit_done_o (bit_done),
    .bit_o      (bit_v)
  );

  // Next state, frame datapath and result pulses.
  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    shad_d    = shad_q;
    bcnt_d    = bcnt_q;
    perr_d    = perr_q;
    serr_d    = serr_q;
    pend_d    = 1'b0;
    pdata_d   = pdata_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    // report the previous frame; runs in parallel with IDLE's start hunt
    if (pend_q) begin
      pe_d = perr_q;
      se_d = serr_q;
      if (!perr_q && !serr_q) begin
        pdata_d = shad_q;
        dv_d    = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_d   = START;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          bcnt_d    = '0;
          perr_d    = 1'b0;
          serr_d    = 1'b0;
        end
      end
      START: begin
        if (mid_vld && vote) state_d = IDLE;   // line came back high: glitch
        else if (bit_done)   state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shad_d = {bit_v, shad_q[DATA_WIDTH-1:1]};
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BW'(DATA_WIDTH - 1))
            state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          perr_d  = bit_v != ((par_typ_q == PAR_ODD) ? ~^shad_q : ^shad_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          serr_d  = ~bit_v;
          pend_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shad_q    <= '0;
      bcnt_q    <= '0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      pend_q    <= 1'b0;
      pdata_q   <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      shad_q    <= shad_d;
      bcnt_q    <= bcnt_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      pend_q    <= pend_d;
      pdata_q   <= pdata_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign bus.P_DATA     = pdata_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.PAR_ERR    = pe_q;
  assign bus.STP_ERR    = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed + randomized bench for uart_rx_frame (DATA_WIDTH=8, OVERSAMPLE=8).
module tb_uart_rx_frame;

  localparam int OS = 8;

  typedef struct {
    int unsigned e;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  pd;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned edge_n = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  pulse_t      got_q[$];
  pulse_t      exp_q[$];
  logic [7:0]  exp_pd;
  int unsigned last_edge = 0;

  uart_rx_frame_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // log every result pulse with the edge that produced it
  always @(negedge clk)
    if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)
      got_q.push_back('{edge_n, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one bit period, optionally with a single-cycle inversion at tick gtick
  task automatic drive_bit(input logic v, input int gtick);
    for (int t = 0; t < OS; t++) begin
      bus.RX_IN = (t == gtick) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  // Send a frame starting on the very next edge and record the expected result.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic sbit,
                            input int gbit, input int gtick);
    int unsigned t0;
    int nb;
    int ones;
    logic perr, serr;
    logic v;
    bus.PAR_EN  = pe;
    bus.PAR_TYP = pt;
    t0 = edge_n + 1;
    nb = 10 + int'(pe);
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                v = 1'b0;
      else if (b <= 8)           v = d[b-1];
      else if (pe && b == 9)     v = pbit;
      else                       v = sbit;
      drive_bit(v, (b == gbit) ? gtick : -1);
    end
    bus.RX_IN = 1'b1;
    // total ones over data+parity must be even (even) or odd (odd)
    ones = $countones(d) + int'(pbit);
    perr = pe && ((ones % 2) != int'(pt));
    serr = !sbit;
    if (!perr && !serr) exp_pd = d;
    last_edge = t0 + nb * OS;
    exp_q.push_back('{last_edge, !perr && !serr, perr, serr, exp_pd});
  endtask

  // wait past the last expected pulse, then match logged pulses to expectations
  task automatic flush();
    pulse_t g, x;
    while (edge_n < last_edge + 2) @(posedge clk);
    #1;
    chk("pulse_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk("pulse_edge", g.e, x.e);
      chk("data_valid", {31'b0, g.dv}, {31'b0, x.dv});
      chk("par_err",    {31'b0, g.pe}, {31'b0, x.pe});
      chk("stp_err",    {31'b0, g.se}, {31'b0, x.se});
      chk("p_data",     {24'b0, g.pd}, {24'b0, x.pd});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_p_data"}, {24'b0, bus.P_DATA}, 32'h0);
    chk({tag, "_dv"},     {31'b0, bus.DATA_VALID}, 32'h0);
    chk({tag, "_pe"},     {31'b0, bus.PAR_ERR}, 32'h0);
    chk({tag, "_se"},     {31'b0, bus.STP_ERR}, 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    logic pe, pt, pb, sb;
    int gb;

    rst = 1'b1;
    bus.RX_IN = 1'b1;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    exp_pd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // good frame with even parity, then the same bits judged as odd parity
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    flush();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    flush();

    // stop error followed back-to-back by a good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    flush();

    // two-cycle low glitch must be rejected silently
    bus.RX_IN = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.RX_IN = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    flush();

    // single-cycle inversion at tick 4 of data bit 3 is voted out
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4);
    flush();

    // reset during data bit 5 abandons the frame
    bus.PAR_EN = 1'b0;
    d = 8'h33;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 5; i++) drive_bit(d[i], -1);
    bus.RX_IN = d[5];
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_zero("mid_reset");
    end
    rst = 1'b0;
    bus.RX_IN = 1'b1;
    exp_pd = 8'h00;
    repeat (20) begin @(posedge clk); #1; end
    flush();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    flush();

    // random frames, random gaps (0 = back-to-back), parity/stop faults, glitches
    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = 1'(($countones(d) % 2) == 1) ^ pt ^ 1'($urandom_range(0, 3) == 0);
      sb = 1'($urandom_range(0, 4) != 0);
      gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      send_frame(d, pe, pt, pb, sb, gb, int'($urandom_range(0, OS - 1)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
